// File: rtl/clk_monitor.sv
// clk_monitor: measures period, high time and phase lag of sig_ref/sig_phase in clk cycles and
// raises locked when the waveform stays in tolerance. Macro CLK_MON_PHASE_EN builds the phase path.
module clk_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_HIGH   = 5,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_ref,
  input  logic             sig_phase,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] phase_lag,
  output logic             locked,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

  localparam int              LC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             ref_s1_q, ref_s2_q, ref_dly_q;
  logic             ref_rise, ref_fall;

  assign ref_rise = ref_s2_q & ~ref_dly_q;
  assign ref_fall = ~ref_s2_q & ref_dly_q;

  function automatic logic within_tol(input logic [CNT_W-1:0] val, input int exp_val);
    int diff;
    diff = int'(val) - exp_val;
    return (diff <= TOL) && (diff >= -TOL);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    stall_d      = 1'b0;
    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (ref_rise) begin
            cnt_d   = CNT_W'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (ref_rise) begin
            period_d     = cnt_q;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_W'(1);
            // High time cannot change on a rise edge, so high_time_q is this period's value.
            if (within_tol(cnt_q, EXP_PERIOD) && within_tol(high_time_q, EXP_HIGH)) begin
              if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LC_W'(1);
              locked_d = (lock_cnt_d == LOCK_MAX);
            end else begin
              lock_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            stall_d    = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            cnt_d      = '0;
            state_d    = ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ref_fall) high_time_d = cnt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      ref_s1_q     <= 1'b0;
      ref_s2_q     <= 1'b0;
      ref_dly_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
      meas_valid_q <= meas_valid_d;
      stall_q      <= stall_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      ref_s1_q     <= sig_ref;
      ref_s2_q     <= ref_s1_q;
      ref_dly_q    <= ref_s2_q;
    end
  end

`ifdef CLK_MON_PHASE_EN
  logic             ph_s1_q, ph_s2_q, ph_dly_q;
  logic             ph_seen_q, ph_seen_d;
  logic             ph_pend_q, ph_pend_d;
  logic [CNT_W-1:0] phase_lag_q, phase_lag_d;
  logic             ph_rise;

  assign ph_rise = ph_s2_q & ~ph_dly_q;

  // A phase rise coincident with a ref rise belongs to the new period; its zero lag is
  // written one cycle later so the enclosing period's value is still reported with meas_valid.
  always_comb begin
    ph_seen_d   = ph_seen_q;
    ph_pend_d   = 1'b0;
    phase_lag_d = phase_lag_q;
    if (!en) begin
      ph_seen_d = 1'b0;
    end else if (state_q == ARM) begin
      if (ref_rise) begin
        ph_seen_d = ph_rise;
        ph_pend_d = ph_rise;
      end
    end else if (state_q == MEASURE) begin
      if (ph_pend_q) phase_lag_d = '0;
      if (ref_rise) begin
        if (!ph_seen_q) phase_lag_d = '1;
        ph_seen_d = ph_rise;
        ph_pend_d = ph_rise;
      end else if ((cnt_q != CNT_MAX) && ph_rise && !ph_seen_q) begin
        phase_lag_d = cnt_q;
        ph_seen_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_s1_q     <= 1'b0;
      ph_s2_q     <= 1'b0;
      ph_dly_q    <= 1'b0;
      ph_seen_q   <= 1'b0;
      ph_pend_q   <= 1'b0;
      phase_lag_q <= '0;
    end else begin
      ph_s1_q     <= sig_phase;
      ph_s2_q     <= ph_s1_q;
      ph_dly_q    <= ph_s2_q;
      ph_seen_q   <= ph_seen_d;
      ph_pend_q   <= ph_pend_d;
      phase_lag_q <= phase_lag_d;
    end
  end

  assign phase_lag = phase_lag_q;
`else
  logic unused_phase;
  assign unused_phase = sig_phase;
  assign phase_lag    = '0;
`endif

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign locked     = locked_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed self-checking bench for clk_monitor (CNT_W=8 so the counter timeout is reachable);
// clk period 10 units, sig_ref edges placed 3 units before a clk rise.
module tb_clk_monitor;

  localparam int CNT_W = 8;

`ifdef CLK_MON_PHASE_EN
  localparam logic [31:0] EXP_LAG   = 32'd4;
  localparam logic [31:0] EXP_NOLAG = 32'hFF;
`else
  localparam logic [31:0] EXP_LAG   = 32'd0;
  localparam logic [31:0] EXP_NOLAG = 32'd0;
`endif

  logic             clk, rst_n, en, sig_ref, sig_phase;
  logic             meas_valid, locked, stall;
  logic [CNT_W-1:0] period, high_time, phase_lag;

  int ref_per  = 100;
  int ref_high = 50;
  bit ref_run  = 1'b0;
  bit phase_on = 1'b1;

  int errors = 0;
  int checks = 0;

  clk_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(10), .EXP_HIGH(5), .TOL(1), .LOCK_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_ref(sig_ref), .sig_phase(sig_phase),
    .meas_valid(meas_valid), .period(period), .high_time(high_time),
    .phase_lag(phase_lag), .locked(locked), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sig_ref = 1'b0;
    #2;
    forever begin
      if (ref_run) begin
        sig_ref = 1'b1;
        #(ref_high);
        sig_ref = 1'b0;
        #(ref_per - ref_high);
      end else begin
        #10;
      end
    end
  end

  initial begin
    sig_phase = 1'b0;
    forever begin
      @(posedge sig_ref);
      #40;
      if (phase_on) sig_phase = 1'b1;
      #(ref_high);
      sig_phase = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < 200);
    check({tag, "_valid_seen"}, 32'(meas_valid), 32'd1);
  endtask

  initial begin
    int cyc;
    int nvalid;
    int rises;
    logic prev_ref;

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_period",     32'(period),     32'd0);
    check("rst_high_time",  32'(high_time),  32'd0);
    check("rst_phase_lag",  32'(phase_lag),  32'd0);
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_stall",      32'(stall),      32'd0);
    rst_n = 1'b1;

    // Nominal: 100-unit ref, 50% duty, phase 40 behind
    en      = 1'b1;
    ref_run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_valid($sformatf("nom%0d", k));
      check($sformatf("nom%0d_period", k), 32'(period),    32'd10);
      check($sformatf("nom%0d_high", k),   32'(high_time), 32'd5);
      check($sformatf("nom%0d_lag", k),    32'(phase_lag), EXP_LAG);
      check($sformatf("nom%0d_locked", k), 32'(locked),    (k >= 4) ? 32'd1 : 32'd0);
    end
    check("nom_stall_quiet", 32'(stall), 32'd0);
    @(negedge clk);
    check("nom_valid_one_cycle", 32'(meas_valid), 32'd0);

    // Reset mid-operation while locked
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_meas_valid", 32'(meas_valid), 32'd0);
    check("mrst_period",     32'(period),     32'd0);
    check("mrst_high_time",  32'(high_time),  32'd0);
    check("mrst_phase_lag",  32'(phase_lag),  32'd0);
    check("mrst_locked",     32'(locked),     32'd0);
    check("mrst_stall",      32'(stall),      32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_valid($sformatf("resume%0d", k));
      check($sformatf("resume%0d_period", k), 32'(period), 32'd10);
      check($sformatf("resume%0d_locked", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
    end

    // Off-frequency: 150-unit period, high 70
    @(negedge sig_ref);
    #1;
    ref_per  = 150;
    ref_high = 70;
    wait_valid("off_a");
    check("off_a_period", 32'(period), 32'd10);
    for (int k = 1; k <= 3; k++) begin
      wait_valid($sformatf("off%0d", k));
      check($sformatf("off%0d_period", k), 32'(period),    32'd15);
      check($sformatf("off%0d_high", k),   32'(high_time), 32'd7);
      check($sformatf("off%0d_locked", k), 32'(locked),    32'd0);
    end
    @(negedge sig_ref);
    #1;
    ref_per  = 100;
    ref_high = 50;
    wait_valid("back_x");
    check("back_x_period", 32'(period), 32'd15);
    check("back_x_locked", 32'(locked), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      wait_valid($sformatf("back%0d", k));
      check($sformatf("back%0d_period", k), 32'(period), 32'd10);
      check($sformatf("back%0d_locked", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
    end

    // Missing phase
    phase_on = 1'b0;
    wait_valid("noph_skip");
    for (int k = 1; k <= 2; k++) begin
      wait_valid($sformatf("noph%0d", k));
      check($sformatf("noph%0d_lag", k),    32'(phase_lag), EXP_NOLAG);
      check($sformatf("noph%0d_period", k), 32'(period),    32'd10);
      check($sformatf("noph%0d_high", k),   32'(high_time), 32'd5);
      check($sformatf("noph%0d_locked", k), 32'(locked),    32'd1);
    end
    phase_on = 1'b1;
    wait_valid("ph_back");
    check("ph_back_lag", 32'(phase_lag), EXP_LAG);

    // Disable mid-period
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis_locked",     32'(locked),     32'd0);
    check("dis_meas_valid", 32'(meas_valid), 32'd0);
    check("dis_period",     32'(period),     32'd10);
    check("dis_high_time",  32'(high_time),  32'd5);
    check("dis_phase_lag",  32'(phase_lag),  EXP_LAG);
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_valid) nvalid++;
    end
    check("dis_no_valid", 32'(nvalid), 32'd0);

    @(negedge sig_ref);
    @(negedge clk);
    en       = 1'b1;
    rises    = 0;
    prev_ref = sig_ref;
    cyc      = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (sig_ref && !prev_ref) rises++;
      prev_ref = sig_ref;
    end while (!meas_valid && cyc < 100);
    check("reen_valid_seen",  32'(meas_valid), 32'd1);
    check("reen_rise_count",  32'(rises),      32'd2);
    check("reen_period",      32'(period),     32'd10);
    for (int k = 2; k <= 4; k++) wait_valid($sformatf("reen%0d", k));
    check("reen4_locked", 32'(locked), 32'd1);

    // Stall: ref held low after the last reload
    cyc    = 0;
    nvalid = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (ref_run && !sig_ref) ref_run = 1'b0;
      if (meas_valid) nvalid++;
    end while (!stall && cyc < 400);
    check("stall_seen",       32'(stall),      32'd1);
    check("stall_delay",      32'(cyc),        32'd255);
    check("stall_locked",     32'(locked),     32'd0);
    check("stall_meas_valid", 32'(meas_valid), 32'd0);
    check("stall_no_valid",   32'(nvalid),     32'd0);
    @(negedge clk);
    check("stall_one_cycle",  32'(stall),      32'd0);

    ref_run = 1'b1;
    wait_valid("rearm");
    check("rearm_period", 32'(period), 32'd10);
    check("rearm_locked", 32'(locked), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
